// File: rtl/led_controller_pkg.sv
// Shared LED timing constants (25 MHz clock cycles) and state encodings for
// the I2C-to-WS2812 LED controller.
`timescale 1ns/1ps
package led_controller_pkg;

    localparam int unsigned T0H  = 10;
    localparam int unsigned T1H  = 20;
    localparam int unsigned TBIT = 31;
    localparam int unsigned TRES = 2000;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } i2c_state_e;

    typedef enum logic [1:0] {
        StTxIdle,
        StTxBits,
        StTxReset
    } tx_state_e;

endpackage

// File: rtl/ws2812_tx.sv
// WS2812 serializer: latches the byte buffer on start_i and sends it MSB first,
// byte 0 at the top of data_i, followed by a reset low period.
`timescale 1ns/1ps
module ws2812_tx #(
    parameter int unsigned NBYTES = 9,
    parameter int unsigned T0H    = led_controller_pkg::T0H,
    parameter int unsigned T1H    = led_controller_pkg::T1H,
    parameter int unsigned TBIT   = led_controller_pkg::TBIT,
    parameter int unsigned TRES   = led_controller_pkg::TRES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [NBYTES*8-1:0] data_i,
    output logic                busy_o,
    output logic                led_o
);
    import led_controller_pkg::*;

    localparam int unsigned NBITS = NBYTES * 8;
    localparam int unsigned CntW  = $clog2(((TRES > TBIT) ? TRES : TBIT) + 1);
    localparam int unsigned BitW  = $clog2(NBITS + 1);

    tx_state_e        state_q;
    logic [NBITS-1:0] shreg_q;
    logic [BitW-1:0]  bits_left_q;
    logic [CntW-1:0]  cyc_q;
    logic [CntW-1:0]  high_cyc;
    logic             led_q;

    assign high_cyc = shreg_q[NBITS-1] ? CntW'(T1H) : CntW'(T0H);
    assign busy_o   = (state_q != StTxIdle);
    assign led_o    = led_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StTxIdle;
            shreg_q     <= '0;
            bits_left_q <= '0;
            cyc_q       <= '0;
            led_q       <= 1'b0;
        end else begin
            case (state_q)
                StTxIdle: begin
                    if (start_i) begin
                        shreg_q     <= data_i;
                        bits_left_q <= BitW'(NBITS);
                        cyc_q       <= '0;
                        led_q       <= 1'b1;
                        state_q     <= StTxBits;
                    end
                end
                StTxBits: begin
                    if (cyc_q == CntW'(TBIT - 1)) begin
                        cyc_q       <= '0;
                        bits_left_q <= bits_left_q - BitW'(1);
                        if (bits_left_q == BitW'(1)) begin
                            led_q   <= 1'b0;
                            state_q <= StTxReset;
                        end else begin
                            // Every bit opens with a high phase.
                            shreg_q <= shreg_q << 1;
                            led_q   <= 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CntW'(1);
                        led_q <= ((cyc_q + CntW'(1)) < high_cyc);
                    end
                end
                StTxReset: begin
                    if (cyc_q == CntW'(TRES - 1)) begin
                        cyc_q   <= '0;
                        state_q <= StTxIdle;
                    end else begin
                        cyc_q <= cyc_q + CntW'(1);
                    end
                end
                default: state_q <= StTxIdle;
            endcase
        end
    end

endmodule

// File: rtl/led_controller.sv
// Write-only I2C target that fills a shadow LED buffer and, on STOP, hands it
// to the WS2812 serializer.
`timescale 1ns/1ps
module led_controller #(
    parameter logic [6:0]  ADDRESS = 7'h4A,
    parameter int unsigned LED_CNT = 3,
    parameter int unsigned T0H     = led_controller_pkg::T0H,
    parameter int unsigned T1H     = led_controller_pkg::T1H,
    parameter int unsigned TBIT    = led_controller_pkg::TBIT,
    parameter int unsigned TRES    = led_controller_pkg::TRES
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    output logic scl_o,
    input  logic sda_i,
    output logic sda_o,
    output logic led_o
);
    import led_controller_pkg::*;

    localparam int unsigned NBYTES = 3 * LED_CNT;
    localparam int unsigned PtrW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    i2c_state_e      state_q;
    logic [2:0]      bit_cnt_q;
    logic [6:0]      shift_q;
    logic [7:0]      rx_byte;
    logic [PtrW-1:0] ptr_q;
    logic            wrote_q;
    logic            sda_q;
    logic            req_q;
    logic [7:0]      shadow_q [NBYTES];

    logic [NBYTES*8-1:0] shadow_flat;
    logic                tx_busy, tx_start, frame_set;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign rx_byte   = {shift_q, sda_s};
    assign frame_set = stop_det & wrote_q;
    assign tx_start  = req_q & ~tx_busy;

    assign scl_o = 1'b1;
    assign sda_o = sda_q;

    // Bus idles high, so synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            req_q      <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            req_q      <= (req_q | frame_set) & ~tx_start;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            wrote_q   <= 1'b0;
            sda_q     <= 1'b1;
            for (int i = 0; i < NBYTES; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (start_det) begin
            state_q   <= StAddr;
            bit_cnt_q <= '0;
            ptr_q     <= '0;
            wrote_q   <= 1'b0;
            sda_q     <= 1'b1;
        end else if (stop_det) begin
            state_q <= StIdle;
            wrote_q <= 1'b0;
            sda_q   <= 1'b1;
        end else begin
            case (state_q)
                StAddr, StData: begin
                    if (scl_rise) begin
                        shift_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StAddr) begin
                                state_q <= (rx_byte == {ADDRESS, 1'b0}) ? StAddrAck : StIgnore;
                            end else begin
                                shadow_q[ptr_q] <= rx_byte;
                                ptr_q   <= (ptr_q == PtrW'(NBYTES - 1)) ? '0 : ptr_q + PtrW'(1);
                                wrote_q <= 1'b1;
                                state_q <= StDataAck;
                            end
                        end
                    end
                end
                StAddrAck, StDataAck: begin
                    // First falling edge pulls SDA low, the next one releases it.
                    if (scl_fall) begin
                        if (sda_q) begin
                            sda_q <= 1'b0;
                        end else begin
                            sda_q   <= 1'b1;
                            state_q <= StData;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NBYTES; i++) begin : g_flat
        assign shadow_flat[(NBYTES-1-i)*8 +: 8] = shadow_q[i];
    end

    ws2812_tx #(
        .NBYTES (NBYTES),
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TRES   (TRES)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .start_i (tx_start),
        .data_i  (shadow_flat),
        .busy_o  (tx_busy),
        .led_o   (led_o)
    );

endmodule

// File: tb/tb_led_controller.sv
// Bench for led_controller: drives an I2C master, decodes led_o pulse widths
// back into bytes and compares them against a byte-array model of the buffer.
`timescale 1ns/1ps
module tb_led_controller;

    localparam int LED_CNT = 3;
    localparam int NBYTES  = 3 * LED_CNT;
    localparam int NBITS   = NBYTES * 8;
    localparam int T0H     = 10;
    localparam int T1H     = 20;
    localparam int TBIT    = 31;
    localparam int TRES    = 2000;

    typedef logic [7:0] frame_t [NBYTES];

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_line, sda_line;
    logic scl_o, sda_o, led_o;

    always #20 clk = ~clk;

    assign scl_line = scl_m & scl_o;
    assign sda_line = sda_m & sda_o;

    led_controller #(
        .ADDRESS (7'h4A),
        .LED_CNT (LED_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .scl_i (scl_line),
        .scl_o (scl_o),
        .sda_i (sda_line),
        .sda_o (sda_o),
        .led_o (led_o)
    );

    // led_o edge recorder, in clock-cycle units
    int   cyc      = 0;
    logic led_prev = 1'b0;
    int   q_rise[$];
    int   q_fall[$];

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        led_prev <= led_o;
        if (led_o && !led_prev) q_rise.push_back(cyc);
        if (!led_o && led_prev) q_fall.push_back(cyc);
    end

    int         n_total = 0;
    int         n_pass  = 0;
    int         qp      = 62;
    frame_t     model;
    logic [7:0] txb [16];
    int         txn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_cyc(qp);
        scl_m = 1'b1; wait_cyc(qp);
        sda_m = 1'b0; wait_cyc(qp);
        scl_m = 1'b0; wait_cyc(qp);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_cyc(qp);
        scl_m = 1'b1; wait_cyc(qp);
        sda_m = 1'b1; wait_cyc(qp);
    endtask

    task automatic i2c_write(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_cyc(qp);
            scl_m = 1'b1; wait_cyc(2 * qp);
            scl_m = 1'b0; wait_cyc(qp);
        end
        sda_m = 1'b1; wait_cyc(qp);
        scl_m = 1'b1; wait_cyc(qp);
        ack = sda_line;
        wait_cyc(qp);
        scl_m = 1'b0; wait_cyc(qp);
    endtask

    // Full write transaction to 0x4A with txb[0..txn-1]; model follows the bytes.
    task automatic write_txn(input string tag);
        logic ack;
        int   p;
        i2c_start();
        i2c_write(8'h94, ack);
        chk({tag, "_addr_ack"}, 32'(ack), 32'd0);
        for (int i = 0; i < txn; i++) begin
            i2c_write(txb[i], ack);
            chk($sformatf("%s_ack%0d", tag, i), 32'(ack), 32'd0);
        end
        i2c_stop();
        p = 0;
        for (int i = 0; i < txn; i++) begin
            model[p] = txb[i];
            p = (p + 1) % NBYTES;
        end
    endtask

    task automatic check_frame(input frame_t exp, input string tag,
                               output int last_rise, output int h7, output int h0);
        int         t, r, f, hi, prev_r, bad_w, bad_p;
        logic [7:0] got [NBYTES];
        t = 0; bad_w = 0; bad_p = 0; prev_r = 0; h7 = 0; h0 = 0;
        while (q_fall.size() < NBITS && t < 20000) begin
            wait_cyc(1);
            t++;
        end
        chk({tag, "_frame_seen"}, 32'(q_fall.size() >= NBITS), 32'd1);
        last_rise = cyc;
        if (q_fall.size() < NBITS) return;
        for (int i = 0; i < NBITS; i++) begin
            r  = q_rise.pop_front();
            f  = q_fall.pop_front();
            hi = f - r;
            if (hi != T0H && hi != T1H) bad_w++;
            if (i > 0 && (r - prev_r) != TBIT) bad_p++;
            got[i / 8][7 - (i % 8)] = (hi == T1H);
            if (i == 0) h7 = hi;
            if (i == 7) h0 = hi;
            prev_r = r;
        end
        last_rise = prev_r;
        for (int i = 0; i < NBYTES; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        end
        chk({tag, "_bad_widths"}, 32'(bad_w), 32'd0);
        chk({tag, "_bad_periods"}, 32'(bad_p), 32'd0);
    endtask

    // After the last bit, led_o must stay low through TRES.
    task automatic expect_idle(input int last_rise, input string tag);
        while (cyc < last_rise + TBIT + TRES + 20) wait_cyc(1);
        chk({tag, "_idle_rises"}, 32'(q_rise.size()), 32'd0);
        chk({tag, "_idle_led"}, 32'(led_o), 32'd0);
    endtask

    task automatic no_frame(input int n, input string tag);
        wait_cyc(n);
        chk({tag, "_no_frame"}, 32'(q_rise.size()), 32'd0);
    endtask

    initial begin
        logic   ack, nack_all;
        int     lr, h7, h0, t, gap;
        frame_t exp_a, exp_b;

        for (int i = 0; i < NBYTES; i++) model[i] = 8'h00;

        // Reset values and quiet line for 200 us
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(5);
        chk("rst_led", 32'(led_o), 32'd0);
        chk("rst_sda", 32'(sda_o), 32'd1);
        chk("rst_scl", 32'(scl_o), 32'd1);
        reset = 1'b0;
        wait_cyc(5000);
        chk("rst_quiet", 32'(q_rise.size()), 32'd0);
        chk("rst_sda_after", 32'(sda_o), 32'd1);

        // 100 kHz write of four bytes
        qp  = 62;
        txn = 4;
        txb[0] = 8'h03; txb[1] = 8'hAB; txb[2] = 8'h36; txb[3] = 8'h84;
        write_txn("w1");
        check_frame(model, "w1", lr, h7, h0);
        chk("w1_first_bit_high", 32'(h7), 32'(T0H));
        chk("w1_bit0_high", 32'(h0), 32'(T1H));
        expect_idle(lr, "w1");

        // Bytes after STOP without START are ignored
        qp = 10;
        scl_m = 1'b0;
        wait_cyc(qp);
        nack_all = 1'b1;
        txb[0] = 8'hD0; txb[1] = 8'h25; txb[2] = 8'h5A;
        txb[3] = 8'h00; txb[4] = 8'h77; txb[5] = 8'h0D;
        for (int i = 0; i < 6; i++) begin
            i2c_write(txb[i], ack);
            nack_all = nack_all & ack;
        end
        i2c_stop();
        chk("nostart_nack", 32'(nack_all), 32'd1);
        no_frame(500, "nostart");

        // Wrong address, then read bit set
        i2c_start();
        i2c_write(8'h96, ack);
        chk("badaddr_nack", 32'(ack), 32'd1);
        i2c_stop();
        no_frame(500, "badaddr");
        i2c_start();
        i2c_write(8'h95, ack);
        chk("read_nack", 32'(ack), 32'd1);
        i2c_stop();
        no_frame(500, "read");

        // Ten bytes wrap the pointer
        txn = 10;
        for (int i = 0; i < 10; i++) txb[i] = 8'(i + 1);
        write_txn("wrap");
        chk("wrap_model_byte0", 32'(model[0]), 32'h0A);
        check_frame(model, "wrap", lr, h7, h0);
        expect_idle(lr, "wrap");

        // Randomized writes
        for (int k = 0; k < 2; k++) begin
            txn = $urandom_range(1, 6);
            for (int i = 0; i < txn; i++) txb[i] = 8'($urandom);
            write_txn($sformatf("rnd%0d", k));
            check_frame(model, $sformatf("rnd%0d", k), lr, h7, h0);
            expect_idle(lr, $sformatf("rnd%0d", k));
        end

        // Second write completes while the first frame is still going out
        txn = 2;
        txb[0] = 8'($urandom); txb[1] = 8'($urandom);
        write_txn("ovl_a");
        exp_a = model;
        t = 0;
        while (q_rise.size() == 0 && t < 5000) begin
            wait_cyc(1);
            t++;
        end
        chk("ovl_a_started", 32'(q_rise.size() > 0), 32'd1);
        qp = 8;
        txb[0] = 8'($urandom); txb[1] = 8'($urandom);
        write_txn("ovl_b");
        exp_b = model;
        chk("ovl_b_midframe", 32'(q_fall.size() < NBITS), 32'd1);
        check_frame(exp_a, "ovl_a", lr, h7, h0);
        t = 0;
        while (q_rise.size() == 0 && t < 5000) begin
            wait_cyc(1);
            t++;
        end
        gap = (q_rise.size() > 0) ? (q_rise[0] - lr) : 0;
        chk("ovl_gap_min", 32'(gap >= TBIT + TRES), 32'd1);
        chk("ovl_gap_max", 32'(gap <= TBIT + TRES + 4), 32'd1);
        check_frame(exp_b, "ovl_b", lr, h7, h0);
        expect_idle(lr, "ovl_b");

        // Reset mid-frame aborts it and clears the buffers
        qp  = 10;
        txn = 1;
        txb[0] = 8'hFF;
        write_txn("rstmid");
        t = 0;
        while (q_rise.size() == 0 && t < 5000) begin
            wait_cyc(1);
            t++;
        end
        wait_cyc(300);
        reset = 1'b1;
        wait_cyc(3);
        chk("rstmid_led", 32'(led_o), 32'd0);
        chk("rstmid_sda", 32'(sda_o), 32'd1);
        reset = 1'b0;
        wait_cyc(2);
        q_rise.delete();
        q_fall.delete();
        for (int i = 0; i < NBYTES; i++) model[i] = 8'h00;
        no_frame(1000, "rstmid");
        txn = 1;
        txb[0] = 8'h5C;
        write_txn("postrst");
        check_frame(model, "postrst", lr, h7, h0);
        expect_idle(lr, "postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_controller.md
LED_CONTROLLER -- requirements
Module: led_controller

Interface
REQ-001 Parameter ADDRESS, default 7'h4A: 7-bit I2C target address.
REQ-002 Parameter LED_CNT, default 3: number of chained WS2812-type LEDs; the buffer holds 3*LED_CNT bytes.
REQ-003 Parameters T0H=10, T1H=20, TBIT=31, TRES=2000, in clk cycles at 25 MHz: 0-bit high time, 1-bit high time, bit period, reset low time.
REQ-004 Port clk, input, 1: the single clock, rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port scl_i, input, 1: I2C SCL as sampled from the pad.
REQ-007 Port scl_o, output, 1: SCL drive, 1 = release; tied to 1 (no clock stretching).
REQ-008 Port sda_i, input, 1: I2C SDA as sampled from the pad.
REQ-009 Port sda_o, output, 1: SDA drive, 1 = release, 0 = pull low.
REQ-010 Port led_o, output, 1: serial LED data line.

Function
REQ-011 scl_i and sda_i shall pass through 2-flop synchronizers; edges are detected on the synchronized copies.
REQ-012 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high; each is recognised in any state, including mid-byte.
REQ-013 I2C FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE; START enters ADDR with bit count 0 and byte pointer 0.
REQ-014 Bits shall be sampled MSB first on SCL rising edges; the 8th rising edge completes a byte.
REQ-015 Address byte equal to {ADDRESS,0}: on the following SCL falling edge sda_o=0 for one SCL period (ACK), then DATA.
REQ-016 Any address mismatch or R/W=1: sda_o stays 1 (NACK), enter IGNORE until the next START.
REQ-017 Each DATA byte is ACKed as in REQ-015 and stored to shadow[ptr]; ptr increments and wraps from 3*LED_CNT-1 to 0.
REQ-018 SCL/SDA activity in IDLE or IGNORE shall be ignored; this covers bytes clocked after a STOP without a new START.
REQ-019 STOP after at least one stored data byte sets a frame request; otherwise STOP only returns to IDLE.
REQ-020 Frame request with the transmitter idle: copy shadow to the output buffer and start a frame. If the transmitter is busy: hold the request, start after the current frame completes.
REQ-021 Frame: bytes 0..3*LED_CNT-1 in order, MSB first; then led_o low for TRES cycles; the transmitter is busy until that ends.
REQ-022 Bit encoding: led_o high for T0H (bit 0) or T1H (bit 1) cycles, then low for the rest of TBIT.
REQ-023 Bytes not written since reset keep the value 0x00.
REQ-024 A START while a frame is being sent shall not disturb that frame; only the shadow buffer is written.

Reset
REQ-025 Reset shall force: FSM=IDLE, ptr=0, no request, transmitter idle, all buffers 0x00, sda_o=1, scl_o=1, led_o=0.
REQ-026 Reset asserted mid-transaction or mid-frame shall abort it immediately, and reset values shall hold until the next START.

Structure
REQ-027 The timing constants T0H/T1H/TBIT/TRES and the FSM state encoding shall live in a shared package led_controller_pkg.
REQ-028 The WS2812 serializer shall be a sub-module ws2812_tx; it takes the buffer plus a start strobe and returns busy and led_o; the I2C target logic stays in the top.

Verification
REQ-029 Reset pulse -> led_o=0, sda_o=1, scl_o=1, no led_o activity for 200 us.
REQ-030 START, 0x94, 0x03, 0xAB, 0x36, 0x84, STOP at 100 kHz -> ACK (sda_o=0) on all 5 ACK slots. Then a frame of 9 bytes: 03 AB 36 84 00 00 00 00 00. Bit 7 of 0x03 shall be a 10-cycle high, bit 0 a 20-cycle high, each bit 31 cycles; then 2000 cycles low.
REQ-031 After REQ-030, bytes 0xD0, 0x25, 0x5A, 0x00, 0x77, 0x0D, STOP without a START -> no ACK and no new frame.
REQ-032 START, 0x96 (wrong address) -> NACK and no frame. START, 0x95 (read) -> NACK and no frame.
REQ-033 Ten data bytes 0x01..0x0A in one write -> pointer wraps, byte0=0x0A; frame = 0A 02 03 04 05 06 07 08 09.
REQ-034 A second write completing mid-frame -> first frame finishes unchanged, then the second frame starts after TRES.
